// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode decoder: tracks E0/F0 prefixes and shift state, maps
// printable keys to ASCII and queues key events in a first-word-fall-through FIFO.
module ps2_key_decoder #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kbd_ready,
  input  logic [7:0]            kbd_scancode,
  input  logic                  ev_pop,
  input  logic                  ovf_clr,
  output logic                  ev_valid,
  output logic [17:0]           ev_data,
  output logic [DEPTH_LOG2:0]   ev_count,
  output logic                  overflow,
  output logic                  shift_held
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned EV_W  = 18;

  typedef enum logic [1:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0} state_t;

  state_t                  state_q, state_d;
  logic                    emit, brk, ext;
  logic                    shift_l_q, shift_r_q;
  logic [EV_W-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q;
  logic                    full, pop, push_ok, drop;
  logic [7:0]              ascii;
  logic [EV_W-1:0]         entry;

  // Keyboard-controller chatter that never starts a key event
  function automatic logic is_discard(input logic [7:0] code);
    case (code)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF, 8'hE1: is_discard = 1'b1;
      default: is_discard = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] key_ascii(input logic [7:0] code, input logic shift);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      8'h45: a = shift ? 8'h29 : 8'h30;
      8'h16: a = shift ? 8'h21 : 8'h31;
      8'h1E: a = shift ? 8'h40 : 8'h32;
      8'h26: a = shift ? 8'h23 : 8'h33;
      8'h25: a = shift ? 8'h24 : 8'h34;
      8'h2E: a = shift ? 8'h25 : 8'h35;
      8'h36: a = shift ? 8'h5E : 8'h36;
      8'h3D: a = shift ? 8'h26 : 8'h37;
      8'h3E: a = shift ? 8'h2A : 8'h38;
      8'h46: a = shift ? 8'h28 : 8'h39;
      8'h29: a = 8'h20;  8'h5A: a = 8'h0A;  8'h66: a = 8'h08;
      8'h0D: a = 8'h09;  8'h76: a = 8'h1B;
      default: a = 8'h00;
    endcase
    // Only the letter range is shifted to uppercase; digit symbols were resolved above
    if (shift && (a >= 8'h61) && (a <= 8'h7A)) a = a - 8'h20;
    key_ascii = a;
  endfunction

  // Prefix state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Prefix next-state and event emission
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    brk     = 1'b0;
    ext     = 1'b0;
    if (kbd_ready) begin
      if (kbd_scancode == 8'hE0) begin
        state_d = ST_E0;
      end else if (kbd_scancode == 8'hF0) begin
        case (state_q)
          ST_IDLE: state_d = ST_F0;
          ST_E0:   state_d = ST_E0F0;
          default: state_d = state_q;
        endcase
      end else if ((state_q == ST_IDLE) && is_discard(kbd_scancode)) begin
        state_d = ST_IDLE;
      end else begin
        emit    = 1'b1;
        brk     = (state_q == ST_F0) || (state_q == ST_E0F0);
        ext     = (state_q == ST_E0) || (state_q == ST_E0F0);
        state_d = ST_IDLE;
      end
    end
  end

  assign ascii = ext ? 8'h00 : key_ascii(kbd_scancode, shift_held);
  assign entry = {brk, ext, kbd_scancode, ascii};

  // Shift tracking on non-extended make/break of either shift key
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_l_q <= 1'b0;
      shift_r_q <= 1'b0;
    end else if (emit && !ext) begin
      if (kbd_scancode == 8'h12) shift_l_q <= !brk;
      if (kbd_scancode == 8'h59) shift_r_q <= !brk;
    end
  end

  assign shift_held = shift_l_q | shift_r_q;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop     = ev_pop && ev_valid;
  assign push_ok = emit && (!full || pop);
  assign drop    = emit && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= entry;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  assign ev_valid = (count_q != '0);
  assign ev_count = count_q;
  assign ev_data  = mem[rd_ptr_q];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: a flag-based prefix/shift/ASCII model
// queues expected events; a negedge monitor pops and compares FIFO output.
module tb_ps2_key_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kbd_ready = 1'b0;
  logic [7:0]  kbd_scancode = 8'h00;
  logic        ev_pop = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        ev_valid;
  logic [17:0] ev_data;
  logic [3:0]  ev_count;
  logic        overflow;
  logic        shift_held;

  ps2_key_decoder #(.DEPTH_LOG2(3)) dut (
    .clk(clk), .rst(rst), .kbd_ready(kbd_ready), .kbd_scancode(kbd_scancode),
    .ev_pop(ev_pop), .ovf_clr(ovf_clr), .ev_valid(ev_valid), .ev_data(ev_data),
    .ev_count(ev_count), .overflow(overflow), .shift_held(shift_held)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [17:0] q[$];
  logic        m_e0 = 1'b0, m_f0 = 1'b0, m_shl = 1'b0, m_shr = 1'b0, m_ovf = 1'b0;
  logic        pop_en = 1'b0;

  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                               8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                               8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                               8'h35, 8'h1A};
  logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                              8'h3E, 8'h46};
  logic [7:0] noise [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF, 8'hE1};
  string      symbols = ")!@#$%^&*(";

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] ref_ascii(input logic [7:0] code, input logic shift);
    for (int i = 0; i < 26; i++)
      if (code == letters[i]) return shift ? 8'(8'h41 + i) : 8'(8'h61 + i);
    for (int i = 0; i < 10; i++)
      if (code == digits[i]) return shift ? 8'(symbols[i]) : 8'(8'h30 + i);
    case (code)
      8'h29: return 8'h20;
      8'h5A: return 8'h0A;
      8'h66: return 8'h08;
      8'h0D: return 8'h09;
      8'h76: return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic is_noise(input logic [7:0] b);
    for (int i = 0; i < 8; i++) if (b == noise[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Reference behaviour for one byte taking effect at the coming clock edge
  function automatic void model_byte(input logic [7:0] b, input logic clr);
    logic drop;
    drop = 1'b0;
    if (b == 8'hE0) begin
      m_e0 = 1'b1; m_f0 = 1'b0;
    end else if (b == 8'hF0) begin
      m_f0 = 1'b1;
    end else if (!m_e0 && !m_f0 && is_noise(b)) begin
      // dropped chatter
    end else begin
      if (q.size() >= 8) drop = 1'b1;
      else q.push_back({m_f0, m_e0, b, m_e0 ? 8'h00 : ref_ascii(b, m_shl | m_shr)});
      if (!m_e0 && b == 8'h12) m_shl = !m_f0;
      if (!m_e0 && b == 8'h59) m_shr = !m_f0;
      m_e0 = 1'b0; m_f0 = 1'b0;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endfunction

  task automatic send(input logic [7:0] b, input logic clr = 1'b0);
    @(negedge clk); #1;
    kbd_ready = 1'b1; kbd_scancode = b; ovf_clr = clr;
    model_byte(b, clr);
    @(posedge clk); #1;
    kbd_ready = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); #1;
    ovf_clr = 1'b1;
    m_ovf = 1'b0;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget;
    pop_en = 1'b1;
    budget = 40;
    while (q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
    idle(2);
  endtask

  // Monitor: compares status every cycle and consumes the head when popping
  always @(negedge clk) begin
    if (rst) begin
      ev_pop = 1'b0;
    end else begin
      check("ev_count", 32'(ev_count), 32'(q.size()));
      check("ev_valid", 32'(ev_valid), 32'(q.size() != 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("shift_held", 32'(shift_held), 32'(m_shl | m_shr));
      if (ev_valid && q.size() != 0) check("ev_data", 32'(ev_data), 32'(q[0]));
      if (ev_valid && pop_en && q.size() != 0) begin
        void'(q.pop_front());
        ev_pop = 1'b1;
      end else begin
        ev_pop = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] b;
    int r;
    #12;
    check("reset_valid", 32'(ev_valid), 32'd0);
    check("reset_count", 32'(ev_count), 32'd0);
    rst = 1'b0;
    idle(2);

    // Single make, then pop
    send(8'h1C);
    idle(1);
    drain();

    // Make/break with shift held
    pop_en = 1'b0;
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12); send(8'h1C);
    idle(1);
    drain();

    // Extended keys and controller chatter
    pop_en = 1'b0;
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hAA); send(8'hFA);
    idle(1);
    drain();

    // Overflow, clear, then simultaneous push/pop while full
    pop_en = 1'b0;
    repeat (10) send(8'h16);
    idle(1);
    check("ovf_count", 32'(ev_count), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    pulse_clr();
    pop_en = 1'b1;
    send(8'h29);
    pop_en = 1'b0;
    idle(2);
    check("full_count", 32'(ev_count), 32'd8);
    drain();

    // Asynchronous reset mid-prefix
    pop_en = 1'b0;
    send(8'h12); send(8'hE0); send(8'hF0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(ev_valid), 32'd0);
    check("arst_count", 32'(ev_count), 32'd0);
    check("arst_shift", 32'(shift_held), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    q.delete();
    m_e0 = 1'b0; m_f0 = 1'b0; m_shl = 1'b0; m_shr = 1'b0; m_ovf = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    send(8'h1C);
    idle(1);
    drain();

    // Randomized traffic with varying pop pressure
    for (int blk = 0; blk < 8; blk++) begin
      for (int n = 0; n < 60; n++) begin
        pop_en = ($urandom_range(0, 7) < 2 * (blk % 4));
        r = $urandom_range(0, 99);
        if (r < 10)      b = 8'hE0;
        else if (r < 22) b = 8'hF0;
        else if (r < 30) b = (r < 26) ? 8'h12 : 8'h59;
        else if (r < 36) b = noise[$urandom_range(0, 7)];
        else if (r < 60) b = letters[$urandom_range(0, 25)];
        else if (r < 75) b = digits[$urandom_range(0, 9)];
        else             b = 8'($urandom);
        send(b, $urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
